calc_seq_engine: RTL

- Parametrised multi-digit integer calculator core for the DE2 front-panel designs.
- Operands are entered one hex nibble at a time into an operand bank. A `go` strobe starts add, subtract, multiply or divide.
- Multiply and divide are multi-cycle: shift-add and restoring division, one bit per clock. They replace single-cycle `*` and `/` operators.
- Outputs feed the existing 7-segment decoders: operand readback plus a 2W-bit result, with completion and status flags.

---
 rtl/calc_pkg.sv | 8 +
 rtl/calc_seq_engine_if.sv | 16 +
 rtl/calc_seq_div.sv | 48 ++++
 rtl/calc_seq_engine.sv | 92 +++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: op encodings, FSM state type and run-length rule shared by the calculator core.
package calc_pkg;
   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int run_len(input logic [1:0] op, input logic b_zero, input int w);
      return (op == OP_MUL || (op == OP_DIV && !b_zero)) ? w : 1;
   endfunction
endpackage

// File: rtl/calc_seq_engine_if.sv
// calc_seq_engine_if: operand entry, command and result bundle of the calculator core.
interface calc_seq_engine_if #(parameter int DIGITS = 2);
   localparam int W = 4 * DIGITS;
   localparam int SELW = (2 * DIGITS > 2) ? $clog2(2 * DIGITS) : 1;
   logic clr, wr_en, go;
   logic [SELW-1:0] wr_sel;
   logic [3:0] wr_data;
   logic [1:0] op;
   logic [W-1:0] opnd_a, opnd_b;
   logic [2*W-1:0] result;
   logic busy, done, neg, div0;
   modport master (output clr, wr_en, wr_sel, wr_data, op, go,
                   input opnd_a, opnd_b, result, busy, done, neg, div0);
   modport slave (input clr, wr_en, wr_sel, wr_data, op, go,
                  output opnd_a, opnd_b, result, busy, done, neg, div0);
endinterface

// File: rtl/calc_seq_div.sv
// calc_seq_div: W-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// quotient/remainder show the step being taken, so they are final while valid is high.
module calc_seq_div #(parameter int W = 8) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
`ifdef CALC_REM_EN
   output logic [W-1:0] remainder,
`endif
   output logic         valid
);
   localparam int CW = $clog2(W + 1);
   logic [W-1:0] rem_q, quo_q, dvs_q, rem_n, quo_n;
   logic [W:0] sh, diff;
   logic [CW-1:0] cnt_q;
   logic ge;
   always_comb begin
      sh = {rem_q, quo_q[W-1]};
      diff = sh - {1'b0, dvs_q};
      ge = sh >= {1'b0, dvs_q};
      rem_n = ge ? diff[W-1:0] : sh[W-1:0];
      quo_n = {quo_q[W-2:0], ge};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= CW'(W);
      end else if (cnt_q != '0) begin
         rem_q <= rem_n;
         quo_q <= quo_n;
         cnt_q <= cnt_q - 1'b1;
      end
   assign quotient = quo_n;
`ifdef CALC_REM_EN
   assign remainder = rem_n;
`endif
   assign valid = cnt_q == CW'(1);
endmodule

// File: rtl/calc_seq_engine.sv
// calc_seq_engine: nibble-entry calculator core with add/sub and multi-cycle mul/div.
// Define CALC_REM_EN to return {remainder, quotient} from div instead of {0, quotient}.
module calc_seq_engine import calc_pkg::*; #(parameter int DIGITS = 2) (
   input logic clk,
   input logic reset,
   calc_seq_engine_if.slave bus
);
   localparam int W = 4 * DIGITS;
   localparam int W2 = 2 * W;
   localparam int SELW = (2 * DIGITS > 2) ? $clog2(2 * DIGITS) : 1;
   localparam int CW = $clog2(W + 1);
   state_t state_q, state_n;
   logic [1:0] op_q;
   logic [W-1:0] a_q, b_q, a_n, b_n, wa_q, wb_q, mp_q, dv_quo, rem_hi;
   logic [W2-1:0] mc_q, acc_q, acc_n, res_n, result_q;
   logic [CW-1:0] cnt_q;
   logic neg_q, div0_q, bz_q, go_ok, fin, dv_valid;
   assign go_ok = bus.go && state_q != RUN;
   assign fin = (op_q == OP_DIV && !bz_q) ? dv_valid : cnt_q == '0;
   always_comb begin
      state_n = bus.clr ? IDLE : state_q == RUN ? (fin ? DONE : RUN) : go_ok ? RUN : IDLE;
      bus.busy = state_q == RUN;
      bus.done = state_q == DONE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_n;
   always_comb begin
      a_n = a_q;
      b_n = b_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.wr_sel == SELW'(i)) a_n[4*(DIGITS-1-i) +: 4] = bus.wr_data;
         if (bus.wr_sel == SELW'(DIGITS + i)) b_n[4*(DIGITS-1-i) +: 4] = bus.wr_data;
      end
   end
   calc_seq_div #(.W(W)) u_div (
      .clk(clk),
      .reset(reset),
      .start(go_ok && !bus.clr && bus.op == OP_DIV && b_q != '0),
      .dividend(a_q),
      .divisor(b_q),
      .quotient(dv_quo),
`ifdef CALC_REM_EN
      .remainder(rem_hi),
`endif
      .valid(dv_valid)
   );
`ifndef CALC_REM_EN
   assign rem_hi = '0;
`endif
   // shift-add step: multiplier LSB selects whether the shifted multiplicand is accumulated
   assign acc_n = acc_q + (mp_q[0] ? mc_q : '0);
   assign res_n = op_q == OP_ADD ? W2'(wa_q) + W2'(wb_q)
                : op_q == OP_SUB ? W2'(wa_q < wb_q ? wb_q - wa_q : wa_q - wb_q)
                : op_q == OP_MUL ? acc_n
                : bz_q ? '1 : {rem_hi, dv_quo};
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         {a_q, b_q, wa_q, wb_q, mp_q} <= '0;
         {mc_q, acc_q, result_q} <= '0;
         {op_q, cnt_q, neg_q, div0_q, bz_q} <= '0;
      end else if (bus.clr) begin
         {a_q, b_q, result_q, cnt_q, neg_q, div0_q} <= '0;
      end else if (go_ok) begin
         op_q <= bus.op;
         wa_q <= a_q;
         wb_q <= b_q;
         bz_q <= b_q == '0;
         acc_q <= '0;
         mc_q <= W2'(a_q);
         mp_q <= b_q;
         cnt_q <= CW'(run_len(bus.op, b_q == '0, W) - 1);
      end else if (state_q == RUN) begin
         acc_q <= acc_n;
         mc_q <= mc_q << 1;
         mp_q <= mp_q >> 1;
         cnt_q <= cnt_q - 1'b1;
         if (fin) begin
            result_q <= res_n;
            neg_q <= op_q == OP_SUB && wa_q < wb_q;
            div0_q <= op_q == OP_DIV && bz_q;
         end
      end else if (bus.wr_en) begin
         a_q <= a_n;
         b_q <= b_n;
      end
   assign bus.opnd_a = a_q;
   assign bus.opnd_b = b_q;
   assign bus.result = result_q;
   assign bus.neg = neg_q;
   assign bus.div0 = div0_q;
endmodule
